// File: rtl/fetch_queue.sv
// fetch_queue: FIFO between fetch and decode. Each accepted instruction is
// tagged with a free-running major ID and leaves through a registered output
// stage that decode can stall. Flush empties the queue and the output stage
// but keeps the major-ID counter running.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to let a push into an empty,
// unstalled queue load the output stage directly (one-edge latency).
module fetch_queue #(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int queueDepth              = 8
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               enable_i,
  input  logic [instructionWidth-1:0]        instruction_i,
  input  logic [addressWidth-1:0]            instructionAddress_i,
  input  logic                               is64Bit_i,
  input  logic [PidSize-1:0]                 instructionPid_i,
  input  logic [TidSize-1:0]                 instructionTid_i,
  input  logic                               flush_i,
  input  logic                               stall_i,
  output logic                               full_o,
  output logic                               empty_o,
  output logic [$clog2(queueDepth):0]        count_o,
  output logic                               enable_o,
  output logic [instructionWidth-1:0]        instruction_o,
  output logic [addressWidth-1:0]            instructionAddress_o,
  output logic                               is64Bit_o,
  output logic [PidSize-1:0]                 instructionPid_o,
  output logic [TidSize-1:0]                 instructionTid_o,
  output logic [instructionCounterWidth-1:0] instructionMajId_o
);

  localparam int PtrW = $clog2(queueDepth);
  localparam int CntW = PtrW + 1;

  typedef struct packed {
    logic [instructionWidth-1:0]        instr;
    logic [addressWidth-1:0]            addr;
    logic                               is64;
    logic [PidSize-1:0]                 pid;
    logic [TidSize-1:0]                 tid;
    logic [instructionCounterWidth-1:0] maj_id;
  } entry_t;

  entry_t                             mem_q [queueDepth];
  logic [PtrW-1:0]                    head_q, head_d;
  logic [PtrW-1:0]                    tail_q, tail_d;
  logic [CntW-1:0]                    count_q, count_d;
  logic [instructionCounterWidth-1:0] maj_id_q, maj_id_d;
  logic                               out_valid_q, out_valid_d;
  entry_t                             out_q, out_d;

  logic   full, empty, push_ok, bypass, store, pop;
  entry_t new_entry;

  // Flags come from the registered count only, so they never depend on inputs.
  assign full  = (count_q == CntW'(queueDepth));
  assign empty = (count_q == '0);

  // Next-state logic for pointers, occupancy, major-ID counter and output stage.
  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that leaves
    // one unassigned would infer a latch.
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    maj_id_d    = maj_id_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;

    new_entry = '{instr:  instruction_i,
                  addr:   instructionAddress_i,
                  is64:   is64Bit_i,
                  pid:    instructionPid_i,
                  tid:    instructionTid_i,
                  maj_id: maj_id_q};

    // A full queue refuses the push even when a pop frees a slot this cycle.
    push_ok = enable_i & ~full & ~flush_i;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass  = push_ok & empty & ~stall_i;
`else
    bypass  = 1'b0;
`endif
    store   = push_ok & ~bypass;
    pop     = ~empty & ~stall_i & ~flush_i;

    // Bypassed entries still consume an ID, exactly like stored ones.
    if (push_ok) maj_id_d = maj_id_q + instructionCounterWidth'(1);

    if (flush_i) begin
      // Flush wins over stall: queue and output stage both empty.
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (store) tail_d = tail_q + PtrW'(1);
      if (pop)   head_d = head_q + PtrW'(1);
      count_d = count_q + CntW'(store) - CntW'(pop);
      if (!stall_i) begin
        out_valid_d = pop | bypass;
        if (pop)         out_d = mem_q[head_q];
        else if (bypass) out_d = new_entry;
      end
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    if (reset_i) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      maj_id_q    <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      maj_id_q    <= maj_id_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  // Entry storage written at the tail.
  // NOTE: the storage array has no reset; count and pointers define which
  // slots are live, so stale contents are never observed.
  always_ff @(posedge clock_i) begin
    if (!reset_i && store) mem_q[tail_q] <= new_entry;
  end

  assign full_o               = full;
  assign empty_o              = empty;
  assign count_o              = count_q;
  assign enable_o             = out_valid_q;
  assign instruction_o        = out_q.instr;
  assign instructionAddress_o = out_q.addr;
  assign is64Bit_o            = out_q.is64;
  assign instructionPid_o     = out_q.pid;
  assign instructionTid_o     = out_q.tid;
  assign instructionMajId_o   = out_q.maj_id;

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed scenarios followed by random traffic,
// checked against a queue-based reference model through a scoreboard. A
// second instance with a 3-bit major-ID counter sees identical stimulus so
// counter wrap-around is observed many times.
module tb_fetch_queue;

  localparam int AW = 64, IW = 32, PW = 20, TW = 16, CW = 64, DEPTH = 8;
  localparam int CNTW = 4, WCW = 3;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_i = 1'b0, enable_i = 1'b0, is64Bit_i = 1'b0, flush_i = 1'b0, stall_i = 1'b0;
  logic [IW-1:0] instruction_i = '0;
  logic [AW-1:0] instructionAddress_i = '0;
  logic [PW-1:0] instructionPid_i = '0;
  logic [TW-1:0] instructionTid_i = '0;

  logic full_o, empty_o, enable_o, is64Bit_o;
  logic [CNTW-1:0] count_o;
  logic [IW-1:0] instruction_o;
  logic [AW-1:0] instructionAddress_o;
  logic [PW-1:0] instructionPid_o;
  logic [TW-1:0] instructionTid_o;
  logic [CW-1:0] instructionMajId_o;

  logic w_full_o, w_empty_o, w_enable_o, w_is64Bit_o;
  logic [CNTW-1:0] w_count_o;
  logic [IW-1:0] w_instruction_o;
  logic [AW-1:0] w_instructionAddress_o;
  logic [PW-1:0] w_instructionPid_o;
  logic [TW-1:0] w_instructionTid_o;
  logic [WCW-1:0] w_instructionMajId_o;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clock_i(clk), .reset_i(reset_i), .enable_i(enable_i),
    .instruction_i(instruction_i), .instructionAddress_i(instructionAddress_i),
    .is64Bit_i(is64Bit_i), .instructionPid_i(instructionPid_i),
    .instructionTid_i(instructionTid_i), .flush_i(flush_i), .stall_i(stall_i),
    .full_o(full_o), .empty_o(empty_o), .count_o(count_o), .enable_o(enable_o),
    .instruction_o(instruction_o), .instructionAddress_o(instructionAddress_o),
    .is64Bit_o(is64Bit_o), .instructionPid_o(instructionPid_o),
    .instructionTid_o(instructionTid_o), .instructionMajId_o(instructionMajId_o)
  );

  fetch_queue #(.instructionCounterWidth(WCW)) dut_w (
    .clock_i(clk), .reset_i(reset_i), .enable_i(enable_i),
    .instruction_i(instruction_i), .instructionAddress_i(instructionAddress_i),
    .is64Bit_i(is64Bit_i), .instructionPid_i(instructionPid_i),
    .instructionTid_i(instructionTid_i), .flush_i(flush_i), .stall_i(stall_i),
    .full_o(w_full_o), .empty_o(w_empty_o), .count_o(w_count_o), .enable_o(w_enable_o),
    .instruction_o(w_instruction_o), .instructionAddress_o(w_instructionAddress_o),
    .is64Bit_o(w_is64Bit_o), .instructionPid_o(w_instructionPid_o),
    .instructionTid_o(w_instructionTid_o), .instructionMajId_o(w_instructionMajId_o)
  );

  typedef struct {
    logic [IW-1:0] instr;
    logic [AW-1:0] addr;
    logic          is64;
    logic [PW-1:0] pid;
    logic [TW-1:0] tid;
    logic [CW-1:0] mid;
  } item_t;

  item_t         mq[$];     // model of queued entries
  item_t         exp_q[$];  // scoreboard: entries due at the output, in order
  item_t         cur;       // instruction fetch is currently presenting
  logic [CW-1:0] mid = '0;  // model major-ID counter
  int            n_vec = 0, n_err = 0;
  bit            mon_on = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic new_fetch();
    cur.instr = $urandom;
    cur.addr  = {$urandom, $urandom};
    cur.is64  = 1'($urandom_range(0, 1));
    cur.pid   = PW'($urandom);
    cur.tid   = TW'($urandom);
    cur.mid   = '0;
  endtask

  // One clock: drive at the falling edge, then advance the model at the rising edge.
  task automatic step(input logic en, input logic stl, input logic fl, input logic rst,
                      output bit acc);
    int    sz;
    bit    can_push, can_pop, byp;
    item_t it;
    @(negedge clk);
    reset_i = rst; enable_i = en; stall_i = stl; flush_i = fl;
    instruction_i = cur.instr; instructionAddress_i = cur.addr; is64Bit_i = cur.is64;
    instructionPid_i = cur.pid; instructionTid_i = cur.tid;
    @(posedge clk);
    acc = 1'b0;
    if (rst) begin
      mq.delete(); exp_q.delete(); mid = '0;
    end else if (fl) begin
      mq.delete();
    end else begin
      sz       = mq.size();
      can_push = en && (sz < DEPTH);
      can_pop  = !stl && (sz > 0);
      byp      = BYP && can_push && (sz == 0) && !stl;
      if (can_pop) exp_q.push_back(mq.pop_front());
      if (can_push) begin
        it = cur; it.mid = mid; mid = mid + 1;
        if (byp) exp_q.push_back(it); else mq.push_back(it);
      end
      acc = can_push;
    end
  endtask

  // Monitor: flags every cycle; compares each fresh output against the scoreboard
  // and checks that a stalled output stage holds its previous values.
  initial begin : monitor
    bit p_rst, p_stall, p_flush;
    logic          l_en, l_is64;
    logic [IW-1:0] l_instr;
    logic [AW-1:0] l_addr;
    logic [PW-1:0] l_pid;
    logic [TW-1:0] l_tid;
    logic [CW-1:0] l_mid;
    item_t e;
    forever begin
      @(posedge clk);
      p_rst = reset_i; p_stall = stall_i; p_flush = flush_i;
      #1;
      if (mon_on) begin
        check("count", 64'(count_o), 64'(mq.size()));
        check("empty", 64'(empty_o), 64'(mq.size() == 0));
        check("full", 64'(full_o), 64'(mq.size() == DEPTH));
        check("wrap_count", 64'(w_count_o), 64'(mq.size()));
        if (p_rst) begin
          check("rst_enable", 64'(enable_o), 64'(0));
          check("rst_instr", 64'(instruction_o), 64'(0));
          check("rst_addr", instructionAddress_o, 64'(0));
          check("rst_is64", 64'(is64Bit_o), 64'(0));
          check("rst_pid", 64'(instructionPid_o), 64'(0));
          check("rst_tid", 64'(instructionTid_o), 64'(0));
          check("rst_majid", instructionMajId_o, 64'(0));
        end else if (p_stall && !p_flush) begin
          check("hold_enable", 64'(enable_o), 64'(l_en));
          check("hold_instr", 64'(instruction_o), 64'(l_instr));
          check("hold_addr", instructionAddress_o, l_addr);
          check("hold_is64", 64'(is64Bit_o), 64'(l_is64));
          check("hold_pid", 64'(instructionPid_o), 64'(l_pid));
          check("hold_tid", 64'(instructionTid_o), 64'(l_tid));
          check("hold_majid", instructionMajId_o, l_mid);
        end else if (enable_o) begin
          check("spurious_output", 64'(exp_q.size() == 0), 64'(0));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_instr", 64'(instruction_o), 64'(e.instr));
            check("out_addr", instructionAddress_o, e.addr);
            check("out_is64", 64'(is64Bit_o), 64'(e.is64));
            check("out_pid", 64'(instructionPid_o), 64'(e.pid));
            check("out_tid", 64'(instructionTid_o), 64'(e.tid));
            check("out_majid", instructionMajId_o, e.mid);
            check("wrap_enable", 64'(w_enable_o), 64'(1));
            check("wrap_majid", 64'(w_instructionMajId_o), 64'(e.mid[WCW-1:0]));
          end
        end else begin
          check("missing_output", 64'(exp_q.size()), 64'(0));
          check("wrap_enable_idle", 64'(w_enable_o), 64'(0));
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
      end
      l_en = enable_o; l_instr = instruction_o; l_addr = instructionAddress_o;
      l_is64 = is64Bit_o; l_pid = instructionPid_o; l_tid = instructionTid_o;
      l_mid = instructionMajId_o;
    end
  end

  initial begin : driver
    bit acc;
    int tries;
    new_fetch();
    mon_on = 1'b1;
    step(0, 0, 0, 1, acc);
    step(0, 0, 0, 1, acc);

    // Single instruction through an empty, unstalled queue.
    cur.instr = 32'h7C22_1A14; cur.addr = 64'h100;
    step(1, 0, 0, 0, acc);
    #1 check("lat_edge1_enable", 64'(enable_o), 64'(BYP));
    new_fetch();
    step(0, 0, 0, 0, acc);
    #1 check("lat_edge2_enable", 64'(enable_o), 64'(!BYP));
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, acc);

    // Fill under stall; the ninth push is held and retried without consuming an ID.
    for (int i = 0; i < DEPTH; i++) begin step(1, 1, 0, 0, acc); new_fetch(); end
    #1 check("fill_full", 64'(full_o), 64'(1));
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, acc);
    check("ninth_rejected", 64'(acc), 64'(0));
    tries = 0;
    do begin step(1, 0, 0, 0, acc); tries++; end while (!acc && tries < 20);
    check("ninth_accepted", 64'(acc), 64'(1));
    new_fetch();
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, acc);

    // Flush with a simultaneous push drops everything; next ID continues.
    for (int i = 0; i < 3; i++) begin step(1, 1, 0, 0, acc); new_fetch(); end
    step(1, 1, 1, 0, acc);
    #1 check("flush_enable", 64'(enable_o), 64'(0));
    step(1, 0, 0, 0, acc); new_fetch();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, acc);

    // Steady push and pop for 20 cycles.
    for (int i = 0; i < 20; i++) begin step(1, 0, 0, 0, acc); new_fetch(); end

    // Stall while the output is valid; pushes keep being accepted.
    for (int i = 0; i < 4; i++) begin step(1, 1, 0, 0, acc); if (acc) new_fetch(); end
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, acc);

    // Random traffic; fetch holds a refused instruction until accepted.
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 3),
           1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 199) < 1), acc);
      if (acc) new_fetch();
    end

    // Drain.
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, acc);
    #2;
    check("leftover_expected", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
